// File: rtl/riscv_pkg.sv
// Shared core types: data-memory arbiter state, owner and command encodings.
// The command struct is sized for the default 32-bit address/data arbiter.
package riscv_pkg;

    localparam int unsigned ARB_AW = 32;
    localparam int unsigned ARB_DW = 32;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_BUSY,
        ARB_DONE
    } arb_state_e;

    typedef enum logic {
        OWN_CORE,
        OWN_DBG
    } arb_owner_e;

    typedef struct packed {
        logic              we;
        logic [ARB_AW-1:0] addr;
        logic [ARB_DW-1:0] wdata;
    } arb_cmd_t;

    // Counter width able to hold 0..max_wait inclusive.
    function automatic int unsigned arb_cnt_width(input int unsigned max_wait);
        if (max_wait < 2) begin
            return 1;
        end
        return $clog2(max_wait + 1);
    endfunction

endpackage

// File: rtl/arb_wait_counter.sv
// Saturating wait counter; flags when the dbg port has waited MAX_WAIT cycles.
module arb_wait_counter
    import riscv_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic sat
);

    localparam int unsigned CW = arb_cnt_width(MAX_WAIT);
    localparam logic [CW-1:0] MAX_VAL = CW'(MAX_WAIT);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (inc && (r_cnt != MAX_VAL)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign sat = (r_cnt == MAX_VAL);

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates the single-port data memory between the MEM stage and the dbg port,
// running one latched command at a time through an IDLE/BUSY/DONE handshake.
module dmem_arbiter
    import riscv_pkg::*;
#(
    parameter int unsigned AW       = 32,
    parameter int unsigned DW       = 32,
    parameter int unsigned MAX_WAIT = 8
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          core_req,
    input  logic          core_we,
    input  logic [AW-1:0] core_addr,
    input  logic [DW-1:0] core_wdata,
    output logic [DW-1:0] core_rdata,
    output logic          core_ack,
    output logic          core_stall,

    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic [AW-1:0] dbg_addr,
    input  logic [DW-1:0] dbg_wdata,
    output logic [DW-1:0] dbg_rdata,
    output logic          dbg_ack,

    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack
);

    arb_state_e    r_state;
    arb_state_e    w_state_next;
    arb_owner_e    r_owner;
    arb_owner_e    w_owner_next;
    arb_cmd_t      r_cmd;
    arb_cmd_t      w_cmd_next;
    logic [DW-1:0] r_core_rdata;
    logic [DW-1:0] r_dbg_rdata;

    logic w_idle;
    logic w_busy;
    logic w_done;
    logic w_grant;
    logic w_grant_dbg;
    logic w_dbg_active;
    logic w_wait_inc;
    logic w_wait_sat;
    logic w_rd_capture;

    assign w_idle = (r_state == ARB_IDLE);
    assign w_busy = (r_state == ARB_BUSY);
    assign w_done = (r_state == ARB_DONE);

    assign w_grant      = w_idle && (core_req || dbg_req);
    assign w_grant_dbg  = w_idle && dbg_req && (!core_req || w_wait_sat);
    // dbg holds the memory from its BUSY cycle through its ack cycle.
    assign w_dbg_active = !w_idle && (r_owner == OWN_DBG);
    assign w_wait_inc   = dbg_req && !w_dbg_active && !w_grant_dbg;

    arb_wait_counter #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_cnt (
        .clk (clk),
        .rst (rst),
        .inc (w_wait_inc),
        .clr (w_grant_dbg),
        .sat (w_wait_sat)
    );

    always_comb begin
        w_state_next = r_state;
        w_owner_next = r_owner;
        w_cmd_next   = r_cmd;
        case (r_state)
            ARB_IDLE: begin
                if (w_grant) begin
                    w_state_next = ARB_BUSY;
                    w_cmd_next   = '0;
                    if (w_grant_dbg) begin
                        w_owner_next               = OWN_DBG;
                        w_cmd_next.we              = dbg_we;
                        w_cmd_next.addr[AW-1:0]    = dbg_addr;
                        w_cmd_next.wdata[DW-1:0]   = dbg_wdata;
                    end else begin
                        w_owner_next               = OWN_CORE;
                        w_cmd_next.we              = core_we;
                        w_cmd_next.addr[AW-1:0]    = core_addr;
                        w_cmd_next.wdata[DW-1:0]   = core_wdata;
                    end
                end
            end
            ARB_BUSY: begin
                if (mem_ack) begin
                    w_state_next = ARB_DONE;
                end
            end
            ARB_DONE: begin
                w_state_next = ARB_IDLE;
            end
            default: begin
                w_state_next = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ARB_IDLE;
            r_owner <= OWN_CORE;
            r_cmd   <= '0;
        end else begin
            r_state <= w_state_next;
            r_owner <= w_owner_next;
            r_cmd   <= w_cmd_next;
        end
    end

    // Only reads completing in BUSY update the owner's load data.
    assign w_rd_capture = w_busy && mem_ack && !r_cmd.we;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_core_rdata <= '0;
            r_dbg_rdata  <= '0;
        end else if (w_rd_capture) begin
            if (r_owner == OWN_DBG) begin
                r_dbg_rdata <= mem_rdata;
            end else begin
                r_core_rdata <= mem_rdata;
            end
        end
    end

    assign mem_req   = w_busy;
    assign mem_we    = w_busy && r_cmd.we;
    assign mem_addr  = w_busy ? r_cmd.addr[AW-1:0]  : '0;
    assign mem_wdata = w_busy ? r_cmd.wdata[DW-1:0] : '0;

    assign core_ack   = w_done && (r_owner == OWN_CORE);
    assign dbg_ack    = w_done && (r_owner == OWN_DBG);
    assign core_rdata = r_core_rdata;
    assign dbg_rdata  = r_dbg_rdata;
    assign core_stall = core_req && !core_ack;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed timing scenarios plus a randomized run
// checked against a golden word memory and a per-transaction scoreboard.
module tb_dmem_arbiter;

    localparam int unsigned AW       = 32;
    localparam int unsigned DW       = 32;
    localparam int unsigned MAX_WAIT = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          core_req, core_we, core_ack, core_stall;
    logic [AW-1:0] core_addr;
    logic [DW-1:0] core_wdata, core_rdata;
    logic          dbg_req, dbg_we, dbg_ack;
    logic [AW-1:0] dbg_addr;
    logic [DW-1:0] dbg_wdata, dbg_rdata;
    logic          mem_req, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic          mem_ack   = 1'b0;

    logic [DW-1:0] mem_array [16];
    logic [DW-1:0] golden    [16];
    int            fixed_lat = 0;
    bit            lat_rand  = 1'b0;
    bit            spurious  = 1'b0;
    int            n_checks  = 0;
    int            n_pass    = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(
        .AW       (AW),
        .DW       (DW),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .core_req   (core_req),
        .core_we    (core_we),
        .core_addr  (core_addr),
        .core_wdata (core_wdata),
        .core_rdata (core_rdata),
        .core_ack   (core_ack),
        .core_stall (core_stall),
        .dbg_req    (dbg_req),
        .dbg_we     (dbg_we),
        .dbg_addr   (dbg_addr),
        .dbg_wdata  (dbg_wdata),
        .dbg_rdata  (dbg_rdata),
        .dbg_ack    (dbg_ack),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack)
    );

    function automatic logic [DW-1:0] init_word(input int i);
        if (i == 4) return 32'hDEAD_BEEF;
        return 32'h1000_0000 + DW'(i) * 32'h0101_0101;
    endfunction

    // Memory model: acks after a programmable number of wait states.
    initial begin
        int mcnt;
        int cur_lat;
        mcnt    = 0;
        cur_lat = 0;
        for (int i = 0; i < 16; i++) mem_array[i] = init_word(i);
        forever begin
            @(negedge clk);
            if (rst || !mem_req) begin
                mcnt      = 0;
                cur_lat   = lat_rand ? int'($urandom_range(0, 4)) : fixed_lat;
                mem_ack   = spurious && !rst && ($urandom_range(0, 3) == 0);
                mem_rdata = $urandom;
            end else if (mcnt >= cur_lat) begin
                mem_ack = 1'b1;
                mcnt    = 0;
                if (mem_we) begin
                    mem_array[mem_addr[5:2]] = mem_wdata;
                    mem_rdata                = $urandom;
                end else begin
                    mem_rdata = mem_array[mem_addr[5:2]];
                end
            end else begin
                mem_ack   = 1'b0;
                mcnt      = mcnt + 1;
                mem_rdata = $urandom;
            end
        end
    end

    task automatic test_reset();
        rst = 1'b1;
        core_req = 1'b1;
        #1;
        n_checks++;
        if (mem_req !== 1'b0 || mem_we !== 1'b0 || mem_addr !== '0 || mem_wdata !== '0)
            $display("FAIL reset_mem: req=%0b we=%0b addr=%h wdata=%h, want all 0",
                     mem_req, mem_we, mem_addr, mem_wdata);
        else n_pass++;
        n_checks++;
        if (core_ack !== 1'b0 || dbg_ack !== 1'b0)
            $display("FAIL reset_ack: core=%0b dbg=%0b, want 0 0", core_ack, dbg_ack);
        else n_pass++;
        n_checks++;
        if (core_rdata !== '0 || dbg_rdata !== '0)
            $display("FAIL reset_rdata: core=%h dbg=%h, want 0", core_rdata, dbg_rdata);
        else n_pass++;
        n_checks++;
        if (core_stall !== 1'b1) $display("FAIL reset_stall_hi: got %0b want 1", core_stall);
        else n_pass++;
        core_req = 1'b0;
        #1;
        n_checks++;
        if (core_stall !== 1'b0) $display("FAIL reset_stall_lo: got %0b want 0", core_stall);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (mem_req !== 1'b0) $display("FAIL reset_release: mem_req=%0b want 0", mem_req);
        else n_pass++;
    endtask

    task automatic test_core_read();
        fixed_lat = 0;
        @(negedge clk);
        core_req = 1'b1; core_we = 1'b0; core_addr = 32'h10; core_wdata = '0;
        #1;
        n_checks++;
        if (core_stall !== 1'b1 || core_ack !== 1'b0)
            $display("FAIL rd_c0: stall=%0b ack=%0b want 1 0", core_stall, core_ack);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h10 || core_stall !== 1'b1)
            $display("FAIL rd_c1: req=%0b we=%0b addr=%h stall=%0b want 1 0 10 1",
                     mem_req, mem_we, mem_addr, core_stall);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (core_ack !== 1'b1 || core_rdata !== 32'hDEAD_BEEF || core_stall !== 1'b0)
            $display("FAIL rd_c2: ack=%0b rdata=%h stall=%0b want 1 deadbeef 0",
                     core_ack, core_rdata, core_stall);
        else n_pass++;
        core_req = 1'b0;
        @(negedge clk);
        n_checks++;
        if (core_ack !== 1'b0 || mem_req !== 1'b0)
            $display("FAIL rd_c3: ack=%0b mem_req=%0b want 0 0", core_ack, mem_req);
        else n_pass++;
    endtask

    task automatic test_simultaneous();
        @(negedge clk);
        core_req = 1'b1; core_we = 1'b1; core_addr = 32'h20; core_wdata = 32'h11;
        dbg_req  = 1'b1; dbg_we  = 1'b0; dbg_addr  = 32'h24; dbg_wdata  = '0;
        @(negedge clk);
        n_checks++;
        if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h20 || mem_wdata !== 32'h11)
            $display("FAIL sim_core_cmd: req=%0b we=%0b addr=%h wdata=%h want 1 1 20 11",
                     mem_req, mem_we, mem_addr, mem_wdata);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (core_ack !== 1'b1 || dbg_ack !== 1'b0 || core_rdata !== 32'hDEAD_BEEF)
            $display("FAIL sim_core_ack: core=%0b dbg=%0b rdata=%h want 1 0 deadbeef",
                     core_ack, dbg_ack, core_rdata);
        else n_pass++;
        golden[8] = 32'h11;
        core_req = 1'b0;
        @(negedge clk);
        n_checks++;
        if (mem_req !== 1'b0 || dbg_ack !== 1'b0)
            $display("FAIL sim_idle: mem_req=%0b dbg_ack=%0b want 0 0", mem_req, dbg_ack);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h24)
            $display("FAIL sim_dbg_cmd: req=%0b we=%0b addr=%h want 1 0 24",
                     mem_req, mem_we, mem_addr);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (dbg_ack !== 1'b1 || dbg_rdata !== golden[9])
            $display("FAIL sim_dbg_ack: ack=%0b rdata=%h want 1 %h", dbg_ack, dbg_rdata, golden[9]);
        else n_pass++;
        dbg_req = 1'b0;
        @(negedge clk);
    endtask

    // Core requests back to back; dbg joins in cycle 3. With MAX_WAIT=2 the
    // counter saturates during the second core access, so grants run
    // core, core, dbg, core (counter cleared), dbg.
    task automatic test_starvation();
        logic [14:0] exp_core;
        logic [14:0] exp_dbg;
        int          core_idx;
        int          dbg_idx;
        exp_core = 15'((1 << 2) | (1 << 5) | (1 << 11));
        exp_dbg  = 15'((1 << 8) | (1 << 14));
        core_idx = 0;
        dbg_idx  = 12;
        @(negedge clk);
        core_req = 1'b1; core_we = 1'b0; core_addr = '0;
        for (int c = 0; c < 15; c++) begin
            if (c > 0) @(negedge clk);
            n_checks++;
            if (core_ack !== exp_core[c] || dbg_ack !== exp_dbg[c])
                $display("FAIL starve_ack_c%0d: core=%0b dbg=%0b want %0b %0b",
                         c, core_ack, dbg_ack, exp_core[c], exp_dbg[c]);
            else n_pass++;
            if (core_ack) begin
                n_checks++;
                if (core_rdata !== golden[core_idx])
                    $display("FAIL starve_core_rdata: got %h want %h", core_rdata, golden[core_idx]);
                else n_pass++;
                core_idx++;
                core_addr = AW'(core_idx * 4);
            end
            if (dbg_ack) begin
                n_checks++;
                if (dbg_rdata !== golden[dbg_idx])
                    $display("FAIL starve_dbg_rdata: got %h want %h", dbg_rdata, golden[dbg_idx]);
                else n_pass++;
                dbg_idx++;
                dbg_addr = AW'(dbg_idx * 4);
            end
            if (c == 3) begin
                dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = AW'(dbg_idx * 4);
            end
        end
        core_req = 1'b0;
        dbg_req  = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_wait_states();
        logic [DW-1:0] wd;
        wd = $urandom;
        fixed_lat = 3;
        @(negedge clk);
        @(negedge clk);
        core_req = 1'b1; core_we = 1'b1; core_addr = 32'h0C; core_wdata = wd;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            n_checks++;
            if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h0C || mem_wdata !== wd ||
                core_ack !== 1'b0)
                $display("FAIL ws_busy_c%0d: req=%0b we=%0b addr=%h wdata=%h ack=%0b want 1 1 0c %h 0",
                         c, mem_req, mem_we, mem_addr, mem_wdata, core_ack, wd);
            else n_pass++;
        end
        @(negedge clk);
        n_checks++;
        if (core_ack !== 1'b1 || mem_req !== 1'b0)
            $display("FAIL ws_ack_c5: ack=%0b mem_req=%0b want 1 0", core_ack, mem_req);
        else n_pass++;
        golden[3] = wd;
        core_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_busy();
        int acks;
        acks = 0;
        fixed_lat = 3;
        @(negedge clk);
        core_req = 1'b1; core_we = 1'b0; core_addr = 32'h04;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        core_req = 1'b0;
        #1;
        n_checks++;
        if (mem_req !== 1'b0 || core_ack !== 1'b0 || core_stall !== 1'b0)
            $display("FAIL rstmid_async: mem_req=%0b ack=%0b stall=%0b want 0 0 0",
                     mem_req, core_ack, core_stall);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if (mem_req !== 1'b0 || core_ack !== 1'b0 || dbg_ack !== 1'b0 ||
            core_rdata !== '0 || dbg_rdata !== '0)
            $display("FAIL rstmid_state: req=%0b cack=%0b dack=%0b crd=%h drd=%h want all 0",
                     mem_req, core_ack, dbg_ack, core_rdata, dbg_rdata);
        else n_pass++;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (core_ack || dbg_ack || mem_req) acks++;
        end
        n_checks++;
        if (acks !== 0) $display("FAIL rstmid_no_ack: activity cycles=%0d want 0", acks);
        else n_pass++;
    endtask

    task automatic test_drop_mid_busy();
        int acks;
        int ack_c;
        acks  = 0;
        ack_c = -1;
        fixed_lat = 2;
        @(negedge clk);
        @(negedge clk);
        core_req = 1'b1; core_we = 1'b0; core_addr = 32'h08;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c == 1) begin
                core_req = 1'b0;
                #1;
                n_checks++;
                if (core_stall !== 1'b0) $display("FAIL drop_stall: got %0b want 0", core_stall);
                else n_pass++;
            end
            if (core_ack) begin
                acks++;
                ack_c = c;
                n_checks++;
                if (core_rdata !== golden[2])
                    $display("FAIL drop_rdata: got %h want %h", core_rdata, golden[2]);
                else n_pass++;
            end
        end
        n_checks++;
        if (acks !== 1 || ack_c !== 4)
            $display("FAIL drop_ack_once: acks=%0d at cycle %0d, want 1 at cycle 4", acks, ack_c);
        else n_pass++;
    endtask

    task automatic test_random();
        bit                 core_pend;
        bit                 dbg_pend;
        int                 core_age;
        int                 dbg_age;
        bit                 prev_mreq;
        logic [AW+DW:0]     cap;
        core_pend = 1'b0; dbg_pend = 1'b0;
        core_age  = 0;    dbg_age  = 0;
        prev_mreq = 1'b0; cap      = '0;
        lat_rand  = 1'b1; spurious = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (mem_req && !prev_mreq) begin
                cap = {mem_we, mem_addr, mem_wdata};
            end else if (mem_req) begin
                n_checks++;
                if ({mem_we, mem_addr, mem_wdata} !== cap)
                    $display("FAIL rnd_mem_stable: got %h want %h", {mem_we, mem_addr, mem_wdata}, cap);
                else n_pass++;
            end
            prev_mreq = mem_req;
            if (core_ack) begin
                n_checks++;
                if (!core_pend || cap !== {core_we, core_addr, core_wdata} || core_age > 30)
                    $display("FAIL rnd_core_txn: pend=%0b cmd=%h want %h age=%0d (max 30)",
                             core_pend, cap, {core_we, core_addr, core_wdata}, core_age);
                else n_pass++;
                if (core_we) begin
                    golden[core_addr[5:2]] = core_wdata;
                end else begin
                    n_checks++;
                    if (core_rdata !== golden[core_addr[5:2]])
                        $display("FAIL rnd_core_rdata: got %h want %h", core_rdata,
                                 golden[core_addr[5:2]]);
                    else n_pass++;
                end
                core_pend = 1'b0;
            end
            if (dbg_ack) begin
                n_checks++;
                if (!dbg_pend || cap !== {dbg_we, dbg_addr, dbg_wdata} || dbg_age > 30)
                    $display("FAIL rnd_dbg_txn: pend=%0b cmd=%h want %h age=%0d (max 30)",
                             dbg_pend, cap, {dbg_we, dbg_addr, dbg_wdata}, dbg_age);
                else n_pass++;
                if (dbg_we) begin
                    golden[dbg_addr[5:2]] = dbg_wdata;
                end else begin
                    n_checks++;
                    if (dbg_rdata !== golden[dbg_addr[5:2]])
                        $display("FAIL rnd_dbg_rdata: got %h want %h", dbg_rdata,
                                 golden[dbg_addr[5:2]]);
                    else n_pass++;
                end
                dbg_pend = 1'b0;
            end
            if (!core_pend && $urandom_range(0, 2) == 0) begin
                core_pend  = 1'b1;
                core_age   = 0;
                core_we    = 1'($urandom_range(0, 1));
                core_addr  = AW'($urandom_range(0, 15) * 4);
                core_wdata = $urandom;
            end
            if (!dbg_pend && $urandom_range(0, 3) == 0) begin
                dbg_pend  = 1'b1;
                dbg_age   = 0;
                dbg_we    = 1'($urandom_range(0, 1));
                dbg_addr  = AW'($urandom_range(0, 15) * 4);
                dbg_wdata = $urandom;
            end
            core_req = core_pend;
            dbg_req  = dbg_pend;
            if (core_pend) core_age++;
            if (dbg_pend) dbg_age++;
            #1;
            n_checks++;
            if (core_stall !== (core_req & ~core_ack))
                $display("FAIL rnd_stall: got %0b want %0b", core_stall, core_req & ~core_ack);
            else n_pass++;
        end
        n_checks++;
        if (core_age > 30 || dbg_age > 30)
            $display("FAIL rnd_final_age: core=%0d dbg=%0d want <= 30", core_age, dbg_age);
        else n_pass++;
        core_req = 1'b0;
        dbg_req  = 1'b0;
        lat_rand = 1'b0;
        spurious = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    initial begin
        rst = 1'b0;
        core_req = 1'b0; core_we = 1'b0; core_addr = '0; core_wdata = '0;
        dbg_req  = 1'b0; dbg_we  = 1'b0; dbg_addr  = '0; dbg_wdata  = '0;
        for (int i = 0; i < 16; i++) golden[i] = init_word(i);
        #2;
        test_reset();
        test_core_read();
        test_simultaneous();
        test_starvation();
        test_wait_states();
        test_reset_mid_busy();
        test_drop_mid_busy();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the core's single-port data memory between the pipeline MEM stage (core port) and a debug/loader port (dbg port). One transaction at a time is run against the memory through a req/ack handshake. The block asserts `core_stall` to freeze the pipeline while a core access is pending, and a wait counter keeps the dbg port from starving under back-to-back core traffic. It sits between the EX_MEM pipeline register and the data memory, and replaces the direct memory hookup.

## Interface
Parameters:
- `AW`, 32, address width
- `DW`, 32, data width
- `MAX_WAIT`, 8, dbg wait cycles before dbg overrides core priority (≥1)

Ports:
- `clk` in 1: sole clock, rising edge
- `rst` in 1: asynchronous, active-high reset
- `core_req` in 1: MEM stage requests access; held with fields stable until `core_ack`
- `core_we` in 1: 1 = write, 0 = read
- `core_addr` in AW: byte address
- `core_wdata` in DW: store data
- `core_rdata` out DW: load data, valid while `core_ack` is high
- `core_ack` out 1: one-cycle completion pulse
- `core_stall` out 1: `core_req & ~core_ack`, combinational
- `dbg_req`, `dbg_we`, `dbg_addr`, `dbg_wdata`, `dbg_rdata`, `dbg_ack`: same semantics as the core port
- `mem_req` out 1: transaction request to memory
- `mem_we` out 1: write enable
- `mem_addr` out AW: address
- `mem_wdata` out DW: write data
- `mem_rdata` in DW: read data, valid with `mem_ack`
- `mem_ack` in 1: memory completion, any latency ≥0 wait states

## Operation
State machine:
- IDLE: no transaction in flight.
  - If a request is present, the winner's `we`/`addr`/`wdata` are latched into the command register and the owner is recorded; the state moves to BUSY.
  - Priority: core wins, unless `wait_cnt == MAX_WAIT` and `dbg_req`, in which case dbg wins.
- BUSY: `mem_req` = 1 and `mem_*` are driven from the command register only.
  - On `mem_ack`, `mem_rdata` is registered into the owner's rdata register and the state moves to DONE.
- DONE: the owner's ack is pulsed for one cycle.
  - No grant is made in DONE. This gives the requester the ack cycle to drop or change its request.
  - The state moves to IDLE.

Wait counter:
- Increments in each cycle where `dbg_req` is high and dbg is not owner, saturating at MAX_WAIT.
- Clears when dbg is granted.
- Holds when `dbg_req` is low.

Data and outputs:
- Writes: the rdata registers are left unchanged.
- `mem_we`/`mem_addr`/`mem_wdata` are 0 outside BUSY.
- A requester dropping `req` while BUSY does not abort the transaction. It completes and the ack is still pulsed.
- If `mem_ack` is asserted outside BUSY, it is ignored.

Reset (any time, including mid-BUSY):
- State → IDLE; owner → core; `wait_cnt`, command register, `core_rdata`, `dbg_rdata` → 0.
- All outputs → 0 except `core_stall`, which follows its equation.
- An in-flight memory transaction is abandoned, and the memory must tolerate `mem_req` dropping.

## Timing
- With a zero-wait memory (`mem_ack` in the first BUSY cycle):
  - Request seen in IDLE at cycle 0 → `mem_req` in cycle 1 → ack in cycle 2 → IDLE in cycle 3.
  - A new grant is possible in cycle 3. Throughput is one access per 3 cycles.
- With N memory wait states, `ack` arrives N+2 cycles after the grant cycle.
- `core_stall` is high from the request cycle through the cycle before `core_ack`, and low in the ack cycle.
- Core and dbg requesting simultaneously in IDLE: core is granted unless the dbg counter is saturated.

## Structure
- `riscv_pkg` additions:
  - `arb_state_e {ARB_IDLE, ARB_BUSY, ARB_DONE}`
  - `arb_owner_e {OWN_CORE, OWN_DBG}`
  - `arb_cmd_t` packed struct {we, addr, wdata}
- Sub-module `arb_wait_counter`: saturating counter with `clk`, `rst`, `inc`, `clr`, and output `sat`, parameterised by MAX_WAIT.
- The FSM, command register and rdata registers live in `dmem_arbiter`.

## Test plan
- Core read, zero-wait memory: `core_req`, `addr` = 0x10, memory returns 0xDEADBEEF in cycle 1 → `core_ack` and `core_rdata` = 0xDEADBEEF in cycle 2; `core_stall` high in cycles 0–1.
- Simultaneous core write (0x20 ← 0x11) and dbg read (0x24) → core is served first, dbg is granted in the IDLE after core's DONE, then `dbg_ack` arrives with the memory data.
- Starvation, MAX_WAIT = 2, `core_req` held continuously, `dbg_req` high → the third grant goes to dbg and `wait_cnt` clears.
- Memory with 3 wait states → `mem_*` fields stay stable for 4 BUSY cycles and `core_ack` arrives 5 cycles after the grant.
- `rst` pulsed in the second BUSY cycle → next cycle: IDLE, `mem_req` = 0, acks = 0, rdata = 0, no ack is ever emitted for the aborted transaction.
- `core_req` dropped mid-BUSY → the transaction completes and `core_ack` is pulsed once.
